// File: rtl/alu_writeback_stage.sv
// alu_writeback_stage
//
// Execute-to-writeback stage that sits directly after the 16-bit ALU.
// Each accepted ALU operation is normalised into {data, dest, wen, flags}.
// The result is buffered in a two-entry head/skid buffer with valid/ready
// handshakes toward the register-file write port. BNE operations are
// resolved here as well. A saturating counter records signed-add overflow
// events for debug.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  upstream handshake (in_ready = NOT skid occupied)
//   alu_op               000 AND, 001 OR, 010 ADDU, 011 ADDS, 111 SLT, 110 BNE
//   alu_result/cout/ovf/comp/slt  raw ALU outputs
//   dest_reg, br_target  destination register index and branch target
//   out_valid / out_ready         downstream handshake for the head entry
//   out_data, out_dest, out_wen, out_flags  head entry ({zero,slt,ovf,cout})
//   br_taken, br_addr    one-cycle taken pulse and the last taken target
//   ovf_count            saturating count of accepted ADDS ops with ovf=1

module alu_writeback_stage #(
    parameter int DATA_W    = 16,
    parameter int REG_AW    = 3,
    parameter int OVF_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           alu_op,
    input  logic [DATA_W-1:0]    alu_result,
    input  logic                 alu_cout,
    input  logic                 alu_ovf,
    input  logic [2:0]           alu_comp,
    input  logic                 alu_slt,
    input  logic [REG_AW-1:0]    dest_reg,
    input  logic [DATA_W-1:0]    br_target,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic [REG_AW-1:0]    out_dest,
    output logic                 out_wen,
    output logic [3:0]           out_flags,
    output logic                 br_taken,
    output logic [DATA_W-1:0]    br_addr,
    output logic [OVF_CNT_W-1:0] ovf_count
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADDU = 3'b010;
    localparam logic [2:0] OP_ADDS = 3'b011;
    localparam logic [2:0] OP_BNE  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;
    localparam logic [2:0] COMP_EQ = 3'b010;

    // Skid entry storage
    logic                 skid_valid;
    logic [DATA_W-1:0]    skid_data;
    logic [REG_AW-1:0]    skid_dest;
    logic                 skid_wen;
    logic [3:0]           skid_flags;

    // Normalised form of the incoming operation
    logic [DATA_W-1:0]    new_data;
    logic                 new_wen;
    logic [3:0]           new_flags;
    logic                 new_cout;
    logic                 new_ovf;
    logic                 new_slt;

    logic accept;
    logic head_free;
    logic bne_taken;

    // in_ready comes straight from a flop, so it has no combinational path
    // from out_ready.
    assign in_ready  = ~skid_valid;
    assign accept    = in_valid & in_ready;
    // The head can take a new entry if it is empty or is leaving this cycle.
    assign head_free = ~out_valid | out_ready;
    assign bne_taken = (alu_op == OP_BNE) && (alu_comp != COMP_EQ);

    always_comb begin
        new_data = alu_result;
        if (alu_op == OP_SLT) begin
            new_data = {{(DATA_W-1){1'b0}}, alu_slt};
        end
        new_cout  = ((alu_op == OP_ADDU) || (alu_op == OP_ADDS)) ? alu_cout : 1'b0;
        new_ovf   = (alu_op == OP_ADDS) ? alu_ovf : 1'b0;
        new_slt   = (alu_op == OP_SLT) ? alu_slt : 1'b0;
        new_flags = {(new_data == '0), new_slt, new_ovf, new_cout};
        new_wen   = (alu_op == OP_AND) || (alu_op == OP_OR) || (alu_op == OP_ADDU) ||
                    (alu_op == OP_ADDS) || (alu_op == OP_SLT);
    end

    // Head/skid buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_dest   <= '0;
            out_wen    <= 1'b0;
            out_flags  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_dest  <= '0;
            skid_wen   <= 1'b0;
            skid_flags <= '0;
        end else if (skid_valid) begin
            // No accept is possible here; wait for the head to drain, then promote skid.
            if (out_ready) begin
                out_data   <= skid_data;
                out_dest   <= skid_dest;
                out_wen    <= skid_wen;
                out_flags  <= skid_flags;
                skid_valid <= 1'b0;
            end
        end else if (accept) begin
            if (head_free) begin
                out_valid <= 1'b1;
                out_data  <= new_data;
                out_dest  <= dest_reg;
                out_wen   <= new_wen;
                out_flags <= new_flags;
            end else begin
                skid_valid <= 1'b1;
                skid_data  <= new_data;
                skid_dest  <= dest_reg;
                skid_wen   <= new_wen;
                skid_flags <= new_flags;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Branch resolution: pulse for one cycle and capture the target only when taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_taken <= 1'b0;
            br_addr  <= '0;
        end else begin
            br_taken <= accept & bne_taken;
            if (accept && bne_taken) begin
                br_addr <= br_target;
            end
        end
    end

    // Saturating overflow event counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_count <= '0;
        end else if (accept && (alu_op == OP_ADDS) && alu_ovf && (ovf_count != '1)) begin
            ovf_count <= ovf_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed testbench for alu_writeback_stage. Inputs change 1 time unit
// after a rising edge. Outputs are checked at the same point, away from
// the edge.

module tb_alu_writeback_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  alu_op;
    logic [15:0] alu_result;
    logic        alu_cout;
    logic        alu_ovf;
    logic [2:0]  alu_comp;
    logic        alu_slt;
    logic [2:0]  dest_reg;
    logic [15:0] br_target;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [2:0]  out_dest;
    logic        out_wen;
    logic [3:0]  out_flags;
    logic        br_taken;
    logic [15:0] br_addr;
    logic [7:0]  ovf_count;

    int checks   = 0;
    int failures = 0;

    alu_writeback_stage #(.DATA_W(16), .REG_AW(3), .OVF_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .alu_result(alu_result), .alu_cout(alu_cout),
        .alu_ovf(alu_ovf), .alu_comp(alu_comp), .alu_slt(alu_slt),
        .dest_reg(dest_reg), .br_target(br_target),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_dest(out_dest), .out_wen(out_wen),
        .out_flags(out_flags), .br_taken(br_taken), .br_addr(br_addr),
        .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [15:0] res, input logic co,
                         input logic ov, input logic [2:0] cmp, input logic sl,
                         input logic [2:0] dst, input logic [15:0] tgt);
        in_valid   = 1'b1;
        alu_op     = op;
        alu_result = res;
        alu_cout   = co;
        alu_ovf    = ov;
        alu_comp   = cmp;
        alu_slt    = sl;
        dest_reg   = dst;
        br_target  = tgt;
    endtask

    task automatic idle(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        drive(3'b000, 16'h0, 1'b0, 1'b0, 3'b000, 1'b0, 3'd0, 16'h0);
        in_valid = 1'b0;
        repeat (3) tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || ovf_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_ctrl: out_valid=%b in_ready=%b ovf_count=%0d required 0 1 0",
                     out_valid, in_ready, ovf_count);
        end
        checks++;
        if (out_data !== 16'h0 || out_flags !== 4'h0 || out_wen !== 1'b0 || br_addr !== 16'h0 || br_taken !== 1'b0) begin
            failures++;
            $display("FAIL reset_data: data=%h flags=%b wen=%b br_addr=%h br_taken=%b required all 0",
                     out_data, out_flags, out_wen, br_addr, br_taken);
        end
        #3 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || br_taken !== 1'b0) begin
                failures++;
                $display("FAIL idle_%0d: out_valid=%b in_ready=%b br_taken=%b required 0 1 0",
                         i, out_valid, in_ready, br_taken);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        drive(3'b010, 16'h0000, 1'b1, 1'b1, 3'b010, 1'b0, 3'd4, 16'h0);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h0000 || out_flags !== 4'b1001 ||
            out_wen !== 1'b1 || out_dest !== 3'd4) begin
            failures++;
            $display("FAIL addu: valid=%b data=%h flags=%b wen=%b dest=%0d required 1 0000 1001 1 4",
                     out_valid, out_data, out_flags, out_wen, out_dest);
        end
        checks++;
        if (ovf_count !== 8'd0) begin
            failures++;
            $display("FAIL addu_ovf_count: got %0d required 0", ovf_count);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL addu_drain: out_valid=%b required 0", out_valid);
        end
        $display("test_add done");
    endtask

    task automatic test_slt();
        out_ready = 1'b1;
        drive(3'b111, 16'h8ACA, 1'b1, 1'b1, 3'b100, 1'b1, 3'd2, 16'h0);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h0001 || out_flags !== 4'b0100 || out_wen !== 1'b1) begin
            failures++;
            $display("FAIL slt: valid=%b data=%h flags=%b wen=%b required 1 0001 0100 1",
                     out_valid, out_data, out_flags, out_wen);
        end
        idle(2);
        $display("test_slt done");
    endtask

    task automatic test_undefined();
        out_ready = 1'b1;
        drive(3'b101, 16'h0000, 1'b1, 1'b1, 3'b001, 1'b1, 3'd6, 16'h0);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h0000 || out_flags !== 4'b1000 || out_wen !== 1'b0) begin
            failures++;
            $display("FAIL undef_op: valid=%b data=%h flags=%b wen=%b required 1 0000 1000 0",
                     out_valid, out_data, out_flags, out_wen);
        end
        idle(2);
        $display("test_undefined done");
    endtask

    task automatic test_bne();
        out_ready = 1'b1;
        drive(3'b110, 16'h1234, 1'b1, 1'b1, 3'b100, 1'b0, 3'd5, 16'h0040);
        tick();
        in_valid = 1'b0;
        checks++;
        if (br_taken !== 1'b1 || br_addr !== 16'h0040 || out_valid !== 1'b1 ||
            out_wen !== 1'b0 || out_flags !== 4'b0000) begin
            failures++;
            $display("FAIL bne_taken: br_taken=%b br_addr=%h valid=%b wen=%b flags=%b required 1 0040 1 0 0000",
                     br_taken, br_addr, out_valid, out_wen, out_flags);
        end
        tick();
        checks++;
        if (br_taken !== 1'b0 || br_addr !== 16'h0040) begin
            failures++;
            $display("FAIL bne_pulse_end: br_taken=%b br_addr=%h required 0 0040", br_taken, br_addr);
        end
        drive(3'b110, 16'h0000, 1'b0, 1'b0, 3'b010, 1'b0, 3'd5, 16'h0080);
        tick();
        in_valid = 1'b0;
        checks++;
        if (br_taken !== 1'b0 || br_addr !== 16'h0040 || out_valid !== 1'b1 || out_wen !== 1'b0) begin
            failures++;
            $display("FAIL bne_not_taken: br_taken=%b br_addr=%h valid=%b wen=%b required 0 0040 1 0",
                     br_taken, br_addr, out_valid, out_wen);
        end
        idle(2);
        $display("test_bne done");
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive(3'b000, 16'h0001, 1'b0, 1'b0, 3'b000, 1'b0, 3'd1, 16'h0);
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h0001 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_first: valid=%b data=%h in_ready=%b required 1 0001 1",
                     out_valid, out_data, in_ready);
        end
        alu_result = 16'h0002; dest_reg = 3'd2;
        tick();
        checks++;
        if (in_ready !== 1'b0 || out_data !== 16'h0001) begin
            failures++;
            $display("FAIL bp_skid: in_ready=%b data=%h required 0 0001", in_ready, out_data);
        end
        alu_result = 16'h0003; dest_reg = 3'd3;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 16'h0001 || out_dest !== 3'd1) begin
                failures++;
                $display("FAIL bp_hold_%0d: in_ready=%b valid=%b data=%h dest=%0d required 0 1 0001 1",
                         i, in_ready, out_valid, out_data, out_dest);
            end
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h0002 || out_dest !== 3'd2 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_drain2: valid=%b data=%h dest=%0d in_ready=%b required 1 0002 2 1",
                     out_valid, out_data, out_dest, in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h0003 || out_dest !== 3'd3) begin
            failures++;
            $display("FAIL bp_drain3: valid=%b data=%h dest=%0d required 1 0003 3",
                     out_valid, out_data, out_dest);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_empty: valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_ovf_count();
        out_ready = 1'b1;
        drive(3'b011, 16'h8000, 1'b0, 1'b1, 3'b100, 1'b0, 3'd7, 16'h0);
        for (int i = 0; i < 300; i++) begin
            tick();
            if (i == 0) begin
                checks++;
                if (out_flags !== 4'b0010 || out_data !== 16'h8000) begin
                    failures++;
                    $display("FAIL adds_flags: flags=%b data=%h required 0010 8000", out_flags, out_data);
                end
            end
            if (i == 9 || i == 253 || i == 254) begin
                checks++;
                if (ovf_count !== 8'(i + 1)) begin
                    failures++;
                    $display("FAIL ovf_count_%0d: got %0d required %0d", i + 1, ovf_count, i + 1);
                end
            end
        end
        checks++;
        if (ovf_count !== 8'd255) begin
            failures++;
            $display("FAIL ovf_saturate: got %0d required 255", ovf_count);
        end
        // Async reset mid-stream: takes effect without waiting for an edge.
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (ovf_count !== 8'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL async_reset: ovf_count=%0d valid=%b in_ready=%b required 0 0 1",
                     ovf_count, out_valid, in_ready);
        end
        in_valid = 1'b0;
        #4 rst_n = 1'b1;
        tick();
        checks++;
        if (ovf_count !== 8'd0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL post_reset: ovf_count=%0d valid=%b required 0 0", ovf_count, out_valid);
        end
        $display("test_ovf_count done");
    endtask

    initial begin
        test_reset();
        test_add();
        test_slt();
        test_undefined();
        test_bne();
        test_back_to_back();
        test_ovf_count();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_writeback_stage.md
Name: alu_writeback_stage

Overview:
- Execute-to-writeback stage directly downstream of the 16-bit ALU.
- Captures the ALU result, carry, overflow, comparison bits and slt bit each cycle the ALU presents a valid operation.
- Normalises the flags per opcode, resolves branch-if-not-equal, and buffers up to two entries in a valid/ready skid buffer toward the register-file write port.
- Keeps a saturating overflow event counter for debug.

Parameters:
- DATA_W, 16, ALU operand/result width.
- REG_AW, 3, destination register index width.
- OVF_CNT_W, 8, overflow event counter width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  ALU output valid this cycle.
- in_ready  out  1  stage can accept; registered, equals NOT skid_valid.
- alu_op  in  3  op code: 000 AND, 001 OR, 010 unsigned add, 011 signed add, 111 SLT, 110 BNE.
- alu_result  in  DATA_W  ALU sum/logic result.
- alu_cout  in  1  ALU carry out.
- alu_ovf  in  1  ALU overflow.
- alu_comp  in  3  comparison: 100 lt, 010 eq, 001 gt.
- alu_slt  in  1  set-on-less-than bit.
- dest_reg  in  REG_AW  destination register index.
- br_target  in  DATA_W  branch target address, used for op 110.
- out_valid  out  1  head entry valid.
- out_ready  in  1  writeback consumer accepts the head entry.
- out_data  out  DATA_W  value to write.
- out_dest  out  REG_AW  destination index.
- out_wen  out  1  register write enable for the head entry.
- out_flags  out  4  {zero, slt, ovf, cout} of the head entry.
- br_taken  out  1  one-cycle pulse: BNE resolved taken.
- br_addr  out  DATA_W  target; holds its last value between pulses.
- ovf_count  out  OVF_CNT_W  saturating count of accepted ops with ovf=1.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, in_ready=1, skid_valid=0, out_data=0, out_dest=0, out_wen=0, out_flags=0, br_taken=0, br_addr=0, ovf_count=0. Reset asserted mid-transfer discards both entries. No output toggles until the first clk edge after rst_n deasserts.
- Accept: an entry is accepted when in_valid and in_ready are both high at a clock edge.
- Normalisation at acceptance:
  - data = {15'b0, alu_slt} for op 111; otherwise alu_result.
  - cout = alu_cout only for ops 010 and 011; otherwise 0.
  - ovf = alu_ovf only for op 011; otherwise 0.
  - slt = alu_slt only for op 111; otherwise 0.
  - zero = (normalised data == 0).
  - wen = 1 for ops 000, 001, 010, 011, 111; wen = 0 for 110 and for undefined ops (100, 101). Undefined ops still flow through with data = alu_result and all flags 0 except zero.
- Branch resolution (op 110):
  - Taken when alu_comp != 010.
  - br_taken pulses high exactly one cycle, in the cycle after acceptance. br_addr is loaded from br_target in the same edge.
  - Not-taken: no pulse; br_addr is unchanged.
  - A BNE still occupies a buffer entry (wen=0) so writeback ordering is preserved.
- Buffer: two entries, head (outputs) and skid.
  - Head empty or draining (out_ready=1): the accepted entry goes to head.
  - Head stalled (out_valid=1, out_ready=0): the accepted entry goes to skid, and in_ready falls on the next cycle.
  - Head drains while skid is full: skid moves to head and in_ready rises next cycle.
  - Accept and drain in the same cycle with skid empty: head is replaced; throughput is 1 per cycle.
- Latency: 1 cycle, input edge to out_valid.
- Output stability: out_* are stable while out_valid=1 and out_ready=0.
- ovf_count: increments on each accepted op 011 with alu_ovf=1. It saturates at 2^OVF_CNT_W-1 and does not wrap.
- Ignored inputs: in_valid while in_ready=0 is ignored. The upstream stage must hold its data.

Test Plan:
- Reset release, then idle: in_valid=0 -> out_valid=0, in_ready=1, ovf_count=0, br_taken never asserted.
- Unsigned add, op 010, alu_result=16'h0000, cout=1, ovf=1, out_ready=1 -> next cycle out_data=0000, out_flags=4'b1001 (zero=1, cout=1, ovf masked to 0), out_wen=1.
- SLT, op 111, alu_result=16'h8ACA, alu_slt=1 -> out_data=16'h0001, out_flags=4'b0100.
- BNE:
  - op 110, comp=100, br_target=16'h0040 -> br_taken=1 for exactly one cycle, br_addr=0040, out_wen=0.
  - Then op 110, comp=010 -> no pulse, br_addr stays 0040.
- Backpressure: out_ready=0, three back-to-back ops with data 1, 2, 3 -> 1 and 2 accepted and in_ready=0 with op 3 held. Raising out_ready drains 1, 2, 3 in order with no loss or duplication.
- Overflow count: 300 accepted op 011 with alu_ovf=1 -> ovf_count=255 and stays there. rst_n pulsed low mid-stream -> ovf_count=0 and out_valid=0 immediately (async).
